wq_rptr_sync_level: RTL and testbench

//  Write-domain receiver for the read pointer of the async FIFO. Synchronizes
//  the Gray read pointer (rptr) into wclk and delivers wq2_rptr to the

---
 rtl/wq_rptr_sync_level_if.sv | 27 ++
 rtl/wq_rptr_sync_level.sv | 87 ++++++++
 tb/tb_wq_rptr_sync_level.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/wq_rptr_sync_level_if.sv
// Read-pointer receiver bundle for the async FIFO write domain.
// The master drives pointers and write-side strobes; the slave returns synchronised status.
interface wq_rptr_sync_level_if #(
    parameter int ADD_SIZE = 4
);
    logic [ADD_SIZE:0] rptr;
    logic [ADD_SIZE:0] wptr;
    logic              winc;
    logic              wfull;
    logic              wclr_stats;
    logic [ADD_SIZE:0] wq2_rptr;
    logic [ADD_SIZE:0] wlevel;
    logic              walmost_full;
    logic [ADD_SIZE:0] whighwater;
    logic              woverflow;
    logic              wptr_err;

    modport master (
        output rptr, wptr, winc, wfull, wclr_stats,
        input  wq2_rptr, wlevel, walmost_full, whighwater, woverflow, wptr_err
    );

    modport slave (
        input  rptr, wptr, winc, wfull, wclr_stats,
        output wq2_rptr, wlevel, walmost_full, whighwater, woverflow, wptr_err
    );
endinterface

// File: rtl/wq_rptr_sync_level.sv
// Write-domain receiver for the async FIFO read pointer: Gray synchroniser,
// fill-level decode, hysteretic almost-full, high-water mark and sticky error flags.
module wq_rptr_sync_level #(
    parameter int ADD_SIZE    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_SET      = 12,
    parameter int AF_CLR      = 10
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    wq_rptr_sync_level_if.slave  bus
);
    localparam int PW = ADD_SIZE + 1;

    typedef logic [ADD_SIZE:0] ptr_t;

    localparam ptr_t DEPTH    = ptr_t'(1 << ADD_SIZE);
    localparam ptr_t AF_SET_L = ptr_t'(AF_SET);
    localparam ptr_t AF_CLR_L = ptr_t'(AF_CLR);

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        for (int i = 0; i < PW; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    // Plain flop chain: only Gray-coded bits cross, no logic between stages.
    ptr_t sync_q [SYNC_STAGES];

    // NOTE: the synchroniser array is reset like any other state because it is
    // built from flops, not a RAM; a stale pointer must not survive reset.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.rptr;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign bus.wq2_rptr = sync_q[SYNC_STAGES-1];

    ptr_t rbin;
    ptr_t wbin;
    ptr_t lvl_nxt;
    ptr_t lvl_sat;
    logic lvl_over;

    // Modulo subtract handles wrap of either pointer.
    assign rbin     = gray2bin(bus.wq2_rptr);
    assign wbin     = gray2bin(bus.wptr);
    assign lvl_nxt  = wbin - rbin;
    assign lvl_over = (lvl_nxt > DEPTH);

    // NOTE: default assignment first so every path writes lvl_sat and no latch is inferred.
    always_comb begin
        lvl_sat = lvl_nxt;
        if (lvl_over) lvl_sat = DEPTH;
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            bus.wlevel       <= '0;
            bus.walmost_full <= 1'b0;
            bus.whighwater   <= '0;
            bus.woverflow    <= 1'b0;
            bus.wptr_err     <= 1'b0;
        end else begin
            bus.wlevel <= lvl_sat;

            // Between the two thresholds the flag holds its previous value.
            if (lvl_nxt >= AF_SET_L)      bus.walmost_full <= 1'b1;
            else if (lvl_nxt <= AF_CLR_L) bus.walmost_full <= 1'b0;

            if (bus.wclr_stats)                bus.whighwater <= lvl_sat;
            else if (lvl_sat > bus.whighwater) bus.whighwater <= lvl_sat;

            // A set event in the clearing cycle wins over the clear.
            if (bus.winc && bus.wfull) bus.woverflow <= 1'b1;
            else if (bus.wclr_stats)   bus.woverflow <= 1'b0;

            if (lvl_over)            bus.wptr_err <= 1'b1;
            else if (bus.wclr_stats) bus.wptr_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wq_rptr_sync_level.sv
// Directed and randomised checks of wq_rptr_sync_level against an integer
// reference model (binary pointers, delay-line queue, min/max arithmetic).
module tb_wq_rptr_sync_level;
    localparam int ADD_SIZE = 4;
    localparam int DEPTH    = 16;
    localparam int PMASK    = 31;
    localparam int SYNC     = 2;
    localparam int AFS      = 12;
    localparam int AFC      = 10;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b0;

    wq_rptr_sync_level_if #(.ADD_SIZE(ADD_SIZE)) bus ();

    wq_rptr_sync_level #(
        .ADD_SIZE(ADD_SIZE), .SYNC_STAGES(SYNC), .AF_SET(AFS), .AF_CLR(AFC)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    always #5 wclk = ~wclk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state, binary pointers as plain integers.
    int rb, wb;
    int rq[$];
    int m_lvl, m_af, m_hw, m_ovf, m_err;

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & PMASK;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        rq    = {};
        for (int i = 0; i < SYNC; i++) rq.push_back(0);
        m_lvl = 0; m_af = 0; m_hw = 0; m_ovf = 0; m_err = 0;
    endtask

    task automatic set_ptrs(input int r, input int w);
        rb = r & PMASK;
        wb = w & PMASK;
        bus.rptr = 5'(gray(rb));
        bus.wptr = 5'(gray(wb));
    endtask

    task automatic check_all(input string tag);
        check({tag, ".wq2_rptr"},     32'(bus.wq2_rptr),     32'(gray(rq[0])));
        check({tag, ".wlevel"},       32'(bus.wlevel),       32'(m_lvl));
        check({tag, ".walmost_full"}, 32'(bus.walmost_full), 32'(m_af));
        check({tag, ".whighwater"},   32'(bus.whighwater),   32'(m_hw));
        check({tag, ".woverflow"},    32'(bus.woverflow),    32'(m_ovf));
        check({tag, ".wptr_err"},     32'(bus.wptr_err),     32'(m_err));
    endtask

    // Advance the model by one write-clock edge using the inputs now applied,
    // then compare all outputs just after the edge.
    task automatic tick(input string tag);
        int raw, sat;
        if (!wrst_n) begin
            model_reset();
        end else begin
            raw = (wb - rq[0]) & PMASK;
            sat = (raw > DEPTH) ? DEPTH : raw;
            m_lvl = sat;
            if (raw >= AFS)      m_af = 1;
            else if (raw <= AFC) m_af = 0;
            if (bus.wclr_stats)  m_hw = sat;
            else if (sat > m_hw) m_hw = sat;
            if (bus.winc && bus.wfull) m_ovf = 1;
            else if (bus.wclr_stats)   m_ovf = 0;
            if (raw > DEPTH)           m_err = 1;
            else if (bus.wclr_stats)   m_err = 0;
            rq.push_back(rb);
            void'(rq.pop_front());
        end
        @(posedge wclk);
        #1;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        set_ptrs(0, 0);
        bus.winc       = 1'b0;
        bus.wfull      = 1'b0;
        bus.wclr_stats = 1'b0;

        // Reset held: pointer activity must not reach any output.
        for (int i = 0; i < 4; i++) begin
            set_ptrs(i * 7 + 3, i * 5 + 9);
            tick("rst_hold");
        end
        set_ptrs(0, 0);
        wrst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick("rst_release");

        // Sync latency: read pointer visible after two edges, level one edge later.
        set_ptrs(0, 3);
        for (int i = 0; i < 3; i++) tick("lat_settle");
        set_ptrs(1, 3);
        tick("lat_e1");
        check("lat_e1_wq2", 32'(bus.wq2_rptr), 32'd0);
        tick("lat_e2");
        check("lat_e2_wq2", 32'(bus.wq2_rptr), 32'd1);
        check("lat_e2_lvl", 32'(bus.wlevel),   32'd3);
        tick("lat_e3");
        check("lat_e3_lvl", 32'(bus.wlevel),   32'd2);

        // Level decode and pointer wrap.
        set_ptrs(0, 5);
        for (int i = 0; i < 3; i++) tick("lvl5");
        check("lvl5_const", 32'(bus.wlevel), 32'd5);
        set_ptrs(30, 1);
        for (int i = 0; i < 3; i++) tick("lvl_wrap");
        check("lvl_wrap_const", 32'(bus.wlevel), 32'd3);
        set_ptrs(0, 1);
        for (int i = 0; i < 3; i++) tick("lvl_back");
        set_ptrs(0, 16);
        tick("lvl_full");
        check("lvl_full_lvl", 32'(bus.wlevel),   32'd16);
        check("lvl_full_err", 32'(bus.wptr_err), 32'd0);
        set_ptrs(0, 20);
        tick("lvl_over");
        check("lvl_over_lvl", 32'(bus.wlevel),   32'd16);
        check("lvl_over_err", 32'(bus.wptr_err), 32'd1);
        set_ptrs(0, 10);
        bus.wclr_stats = 1'b1;
        tick("err_clr");
        bus.wclr_stats = 1'b0;
        check("err_clr_const", 32'(bus.wptr_err), 32'd0);

        // Almost-full hysteresis.
        set_ptrs(0, 11); tick("af_11");
        set_ptrs(0, 12); tick("af_12");
        check("af_12_set", 32'(bus.walmost_full), 32'd1);
        set_ptrs(0, 11); tick("af_11_hold");
        check("af_11_hold_c", 32'(bus.walmost_full), 32'd1);
        set_ptrs(0, 10); tick("af_10_clr");
        check("af_10_clr_c", 32'(bus.walmost_full), 32'd0);
        set_ptrs(0, 11); tick("af_11_stay");
        check("af_11_stay_c", 32'(bus.walmost_full), 32'd0);

        // Sticky overflow and clear priority.
        bus.winc = 1'b1; bus.wfull = 1'b1;
        tick("ovf_set");
        check("ovf_set_c", 32'(bus.woverflow), 32'd1);
        bus.winc = 1'b0; bus.wfull = 1'b0;
        tick("ovf_hold");
        bus.wclr_stats = 1'b1;
        tick("ovf_clr");
        check("ovf_clr_c", 32'(bus.woverflow), 32'd0);
        bus.winc = 1'b1; bus.wfull = 1'b1;
        tick("ovf_clr_win");
        check("ovf_clr_win_c", 32'(bus.woverflow), 32'd1);
        bus.winc = 1'b0; bus.wfull = 1'b0; bus.wclr_stats = 1'b0;
        tick("ovf_idle");

        // High-water mark, clear reload and asynchronous reset.
        set_ptrs(0, 3); bus.wclr_stats = 1'b1; tick("hw_3");
        bus.wclr_stats = 1'b0;
        set_ptrs(0, 9); tick("hw_9");
        set_ptrs(0, 4); tick("hw_4");
        check("hw_max_c", 32'(bus.whighwater), 32'd9);
        bus.wclr_stats = 1'b1; tick("hw_clr");
        check("hw_clr_c", 32'(bus.whighwater), 32'd4);
        bus.wclr_stats = 1'b0;
        set_ptrs(0, 7); tick("hw_7");
        #2;
        wrst_n = 1'b0;
        #1;
        model_reset();
        check("hw_async_c", 32'(bus.whighwater), 32'd0);
        check_all("async_rst");
        set_ptrs(0, 0);
        tick("async_hold");
        #2;
        wrst_n = 1'b1;

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int r, w;
            r = rb; w = wb;
            if ($urandom_range(0, 19) == 0) w = $urandom_range(0, PMASK);
            else                            w = w + $urandom_range(0, 2);
            r = r + $urandom_range(0, 2);
            set_ptrs(r, w);
            bus.winc       = 1'($urandom_range(0, 1));
            bus.wfull      = 1'($urandom_range(0, 3) == 0);
            bus.wclr_stats = 1'($urandom_range(0, 15) == 0);
            wrst_n         = ($urandom_range(0, 99) != 0);
            tick("rand");
        end
        wrst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
